// File: rtl/exm_stack_unit.sv
// exm_stack_unit: hardware stack engine that pushes/pops single words or
// multi-word PCs (with optional {Z,N,C} flag packing) to a word memory.
//
// Optional feature: define EXM_STACK_GUARD_EN to enable stack bound checks
// (push needs SP-n+1 >= STACK_LIMIT, pop needs SP+n <= SP_INIT). Without it
// no checks are made, SP wraps freely and o_error stays 0.
//
// Ports:
//   i_clk, i_reset          clock, async active-low reset
//   i_valid/o_ready         request handshake; i_op 00 push word, 01 pop word,
//                           10 push PC, 11 pop PC
//   i_data, i_pc            push payloads; i_flags_en/i_flags save/restore flags
//   o_mem_*/i_mem_rdata     word memory port, read data one cycle after o_mem_re
//   o_done, o_error         completion pulse and bound violation
//   o_data, o_pc, o_flags   popped results (held), o_flags_valid with o_done
//   o_sp                    current stack pointer
module exm_stack_unit #(
  parameter int unsigned     DATA_W      = 16,
  parameter int unsigned     ADDR_W      = 16,
  parameter int unsigned     PC_W        = 32,
  parameter logic [ADDR_W-1:0] SP_INIT   = ADDR_W'('h07FF),
  parameter logic [ADDR_W-1:0] STACK_LIMIT = ADDR_W'('h0400)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_data,
  input  logic [PC_W-1:0]   i_pc,
  input  logic              i_flags_en,
  input  logic [2:0]        i_flags,
  output logic              o_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_mem_re,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_done,
  output logic              o_error,
  output logic [DATA_W-1:0] o_data,
  output logic [PC_W-1:0]   o_pc,
  output logic [2:0]        o_flags,
  output logic              o_flags_valid,
  output logic [ADDR_W-1:0] o_sp
);

  localparam int unsigned NW = PC_W / DATA_W;
  localparam int unsigned CW = $clog2(NW + 1);
  localparam int unsigned GW = ADDR_W + 2;
`ifdef EXM_STACK_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_PUSH, S_POP, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sp_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     cap_q, cap_d;
  logic [1:0]        op_q, op_d;
  logic              fen_q, fen_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   acc_q, acc_d;
  logic              rd_pend_q;

  logic              ready_d, we_d, re_d, done_d, err_d, fv_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d, data_d;
  logic [PC_W-1:0]   pcout_d;
  logic [2:0]        flags_d;

  logic [CW-1:0]     n_req;
  logic [CW-1:0]     wsel;
  logic [PC_W-1:0]   pc_flagged;
  logic [PC_W-1:0]   pop_full;
  logic              push_ok, pop_ok;

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q       <= S_IDLE;
      o_sp          <= SP_INIT;
      cnt_q         <= '0;
      cap_q         <= '0;
      op_q          <= '0;
      fen_q         <= 1'b0;
      pc_q          <= '0;
      acc_q         <= '0;
      rd_pend_q     <= 1'b0;
      o_ready       <= 1'b1;
      o_mem_addr    <= '0;
      o_mem_wdata   <= '0;
      o_mem_we      <= 1'b0;
      o_mem_re      <= 1'b0;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
      o_data        <= '0;
      o_pc          <= '0;
      o_flags       <= '0;
      o_flags_valid <= 1'b0;
    end else begin
      state_q       <= state_d;
      o_sp          <= sp_d;
      cnt_q         <= cnt_d;
      cap_q         <= cap_d;
      op_q          <= op_d;
      fen_q         <= fen_d;
      pc_q          <= pc_d;
      acc_q         <= acc_d;
      rd_pend_q     <= o_mem_re;
      o_ready       <= ready_d;
      o_mem_addr    <= addr_d;
      o_mem_wdata   <= wdata_d;
      o_mem_we      <= we_d;
      o_mem_re      <= re_d;
      o_done        <= done_d;
      o_error       <= err_d;
      o_data        <= data_d;
      o_pc          <= pcout_d;
      o_flags       <= flags_d;
      o_flags_valid <= fv_d;
    end
  end

  // Next state and next registered output values
  always_comb begin
    state_d = state_q;
    sp_d    = o_sp;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    op_d    = op_q;
    fen_d   = fen_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    addr_d  = o_mem_addr;
    wdata_d = o_mem_wdata;
    we_d    = 1'b0;
    re_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    fv_d    = 1'b0;
    data_d  = o_data;
    pcout_d = o_pc;
    flags_d = o_flags;

    n_req = i_op[1] ? CW'(NW) : CW'(1);
    wsel  = cnt_q - CW'(1);

    pc_flagged = i_pc;
    if (i_flags_en) pc_flagged[PC_W-1 -: 3] = i_flags;

    // Bounds computed two bits wider so SP near either end cannot alias
    push_ok = !GUARD_EN ||
              ((GW'(o_sp) + GW'(1)) >= (GW'(STACK_LIMIT) + GW'(n_req)));
    pop_ok  = !GUARD_EN ||
              ((GW'(o_sp) + GW'(n_req)) <= GW'(SP_INIT));

    // Final popped value: last word arrives in DRAIN, LS word sits at index 0
    pop_full = acc_q;
    pop_full[32'(cap_q) * DATA_W +: DATA_W] = i_mem_rdata;

    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          op_d  = i_op;
          fen_d = i_flags_en;
          pc_d  = pc_flagged;
          cap_d = '0;
          acc_d = '0;
          cnt_d = n_req - CW'(1);
          if (!i_op[0]) begin
            if (!push_ok) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              err_d   = 1'b1;
            end else begin
              // First write goes out at the current SP, MS word first
              state_d = S_PUSH;
              addr_d  = o_sp;
              we_d    = 1'b1;
              wdata_d = i_op[1] ? pc_flagged[PC_W-1 -: DATA_W] : i_data;
            end
          end else begin
            if (!pop_ok) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              err_d   = 1'b1;
            end else begin
              state_d = S_POP;
              sp_d    = o_sp + ADDR_W'(1);
              addr_d  = o_sp + ADDR_W'(1);
              re_d    = 1'b1;
            end
          end
        end
      end

      S_PUSH: begin
        sp_d = o_sp - ADDR_W'(1);
        if (cnt_q != '0) begin
          addr_d  = o_sp - ADDR_W'(1);
          we_d    = 1'b1;
          wdata_d = pc_q[32'(wsel) * DATA_W +: DATA_W];
          cnt_d   = cnt_q - CW'(1);
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end

      S_POP: begin
        // Data from the previous cycle's read is on i_mem_rdata now
        if (rd_pend_q) begin
          acc_d[32'(cap_q) * DATA_W +: DATA_W] = i_mem_rdata;
          cap_d = cap_q + CW'(1);
        end
        if (cnt_q != '0) begin
          sp_d   = o_sp + ADDR_W'(1);
          addr_d = o_sp + ADDR_W'(1);
          re_d   = 1'b1;
          cnt_d  = cnt_q - CW'(1);
        end else begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        if (op_q[1]) begin
          pcout_d = pop_full;
          if (fen_q) begin
            flags_d                = pop_full[PC_W-1 -: 3];
            pcout_d[PC_W-1 -: 3]   = 3'b000;
            fv_d                   = 1'b1;
          end else begin
            flags_d = 3'b000;
          end
        end else begin
          data_d = i_mem_rdata;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

endmodule

// File: tb/tb_exm_stack_unit.sv
// Randomized self-checking bench for exm_stack_unit. A simple array-backed
// stack model predicts memory traffic, completion latency, SP and results.
module tb_exm_stack_unit;

  localparam logic [15:0] SP_INIT     = 16'h07FF;
  localparam logic [15:0] STACK_LIMIT = 16'h0400;
`ifdef EXM_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_valid = 1'b0;
  logic [1:0]  i_op = '0;
  logic [15:0] i_data = '0;
  logic [31:0] i_pc = '0;
  logic        i_flags_en = 1'b0;
  logic [2:0]  i_flags = '0;
  logic        o_ready;
  logic [15:0] o_mem_addr;
  logic [15:0] o_mem_wdata;
  logic        o_mem_we;
  logic        o_mem_re;
  logic [15:0] i_mem_rdata;
  logic        o_done;
  logic        o_error;
  logic [15:0] o_data;
  logic [31:0] o_pc;
  logic [2:0]  o_flags;
  logic        o_flags_valid;
  logic [15:0] o_sp;

  exm_stack_unit dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_op(i_op),
    .i_data(i_data), .i_pc(i_pc), .i_flags_en(i_flags_en), .i_flags(i_flags),
    .o_ready(o_ready), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_we(o_mem_we), .o_mem_re(o_mem_re), .i_mem_rdata(i_mem_rdata),
    .o_done(o_done), .o_error(o_error), .o_data(o_data), .o_pc(o_pc),
    .o_flags(o_flags), .o_flags_valid(o_flags_valid), .o_sp(o_sp)
  );

  always #5 i_clk = ~i_clk;

  // Synchronous word memory: read data appears the cycle after o_mem_re
  logic [15:0] mem [0:65535];
  always @(posedge i_clk) begin
    if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
    if (o_mem_re) i_mem_rdata <= mem[o_mem_addr];
  end

  // Strobe trace
  logic [31:0] wr_q[$];
  logic [15:0] rd_q[$];
  int          both_cnt = 0;
  int          done_seen = 0;
  always @(negedge i_clk) begin
    if (o_mem_we) wr_q.push_back({o_mem_addr, o_mem_wdata});
    if (o_mem_re) rd_q.push_back(o_mem_addr);
    if (o_mem_we && o_mem_re) both_cnt++;
    if (o_done) done_seen++;
  end

  // Reference stack model
  logic [15:0] ref_mem [0:65535];
  logic [15:0] m_sp = SP_INIT;
  logic [15:0] m_data = '0;
  logic [31:0] m_pc = '0;
  logic [2:0]  m_flags = '0;

  int cnt_cmp = 0;
  int cnt_fail = 0;

  task automatic run_op(input logic [1:0] op, input logic [15:0] data,
                        input logic [31:0] pc, input logic fen,
                        input logic [2:0] flags, input string tag);
    int          n, lat, got;
    bit          push, err, exp_fv;
    logic [31:0] ew[$];
    logic [15:0] er[$];
    logic [31:0] pcw, full;
    logic [15:0] a, w;
    n      = op[1] ? 2 : 1;
    push   = !op[0];
    exp_fv = 1'b0;
    if (push) err = GUARD && (int'(m_sp) + 1 < int'(STACK_LIMIT) + n);
    else      err = GUARD && (int'(m_sp) + n > int'(SP_INIT));
    if (!err) begin
      if (push) begin
        pcw = pc;
        if (fen) pcw[31:29] = flags;
        for (int k = 0; k < n; k++) begin
          w = op[1] ? ((k == 0) ? pcw[31:16] : pcw[15:0]) : data;
          a = m_sp - 16'(k);
          ew.push_back({a, w});
          ref_mem[a] = w;
        end
        m_sp = m_sp - 16'(n);
      end else begin
        full = '0;
        for (int k = 0; k < n; k++) begin
          a = m_sp + 16'(k + 1);
          er.push_back(a);
          if (k == 0) full[15:0] = ref_mem[a];
          else        full[31:16] = ref_mem[a];
        end
        m_sp = m_sp + 16'(n);
        if (op[1]) begin
          m_flags = fen ? full[31:29] : 3'b000;
          if (fen) full[31:29] = 3'b000;
          m_pc   = full;
          exp_fv = fen;
        end else begin
          m_data = full[15:0];
        end
      end
    end
    lat = err ? 1 : (push ? n + 1 : n + 2);

    @(negedge i_clk);
    cnt_cmp++;
    if (o_ready !== 1'b1) begin
      cnt_fail++; $display("FAIL %s ready_before: got %b want 1", tag, o_ready);
    end
    i_valid = 1'b1; i_op = op; i_data = data; i_pc = pc;
    i_flags_en = fen; i_flags = flags;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0; i_data = 16'($urandom); i_pc = $urandom;
    i_flags_en = 1'($urandom); i_flags = 3'($urandom); i_op = 2'($urandom);
    wr_q.delete(); rd_q.delete();
    got = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge i_clk);
      if (k == 1) begin
        cnt_cmp++;
        if (o_ready !== 1'b0) begin
          cnt_fail++; $display("FAIL %s ready_busy: got %b want 0", tag, o_ready);
        end
      end
      if (o_done === 1'b1) begin got = k; break; end
    end
    cnt_cmp++;
    if (got != lat) begin
      cnt_fail++; $display("FAIL %s latency: got %0d want %0d (0 = timeout)", tag, got, lat);
    end
    cnt_cmp++;
    if (o_error !== err) begin
      cnt_fail++; $display("FAIL %s error: got %b want %b", tag, o_error, err);
    end
    cnt_cmp++;
    if (o_sp !== m_sp) begin
      cnt_fail++; $display("FAIL %s sp: got %h want %h", tag, o_sp, m_sp);
    end
    cnt_cmp++;
    if (o_flags_valid !== exp_fv) begin
      cnt_fail++; $display("FAIL %s flags_valid: got %b want %b", tag, o_flags_valid, exp_fv);
    end
    cnt_cmp++;
    if (o_data !== m_data || o_pc !== m_pc || o_flags !== m_flags) begin
      cnt_fail++;
      $display("FAIL %s results: got data %h pc %h flags %b want data %h pc %h flags %b",
               tag, o_data, o_pc, o_flags, m_data, m_pc, m_flags);
    end
    cnt_cmp++;
    if (wr_q.size() != ew.size() || rd_q.size() != er.size()) begin
      cnt_fail++;
      $display("FAIL %s strobe_count: got wr %0d rd %0d want wr %0d rd %0d",
               tag, wr_q.size(), rd_q.size(), ew.size(), er.size());
    end else begin
      foreach (ew[i]) begin
        cnt_cmp++;
        if (wr_q[i] !== ew[i]) begin
          cnt_fail++; $display("FAIL %s write%0d: got %h want %h", tag, i, wr_q[i], ew[i]);
        end
      end
      foreach (er[i]) begin
        cnt_cmp++;
        if (rd_q[i] !== er[i]) begin
          cnt_fail++; $display("FAIL %s read%0d: got %h want %h", tag, i, rd_q[i], er[i]);
        end
      end
    end
    @(negedge i_clk);
    cnt_cmp++;
    if (o_done !== 1'b0 || o_ready !== 1'b1) begin
      cnt_fail++; $display("FAIL %s back_to_idle: got done %b ready %b want 0 1", tag, o_done, o_ready);
    end
  endtask

  task automatic test_reset();
    #1 i_reset = 1'b0;
    #1;
    cnt_cmp++;
    if (o_ready !== 1'b1 || o_sp !== SP_INIT) begin
      cnt_fail++; $display("FAIL reset_ready_sp: got %b %h want 1 %h", o_ready, o_sp, SP_INIT);
    end
    cnt_cmp++;
    if ({o_mem_we, o_mem_re, o_done, o_error, o_flags_valid} !== 5'b0 ||
        o_mem_addr !== 16'h0 || o_mem_wdata !== 16'h0) begin
      cnt_fail++; $display("FAIL reset_strobes: got we%b re%b done%b err%b fv%b addr %h wd %h want all 0",
                           o_mem_we, o_mem_re, o_done, o_error, o_flags_valid, o_mem_addr, o_mem_wdata);
    end
    cnt_cmp++;
    if (o_data !== 16'h0 || o_pc !== 32'h0 || o_flags !== 3'b0) begin
      cnt_fail++; $display("FAIL reset_results: got %h %h %b want 0 0 0", o_data, o_pc, o_flags);
    end
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;
  endtask

  task automatic test_vectors();
    run_op(2'b00, 16'hABCD, 32'h0, 1'b0, 3'b0, "push_word");
    cnt_cmp++;
    if (o_sp !== 16'h07FE || wr_q.size() != 1 || wr_q[0] !== 32'h07FF_ABCD) begin
      cnt_fail++; $display("FAIL vec_push_word: got sp %h writes %0d want 07fe and 07ffabcd", o_sp, wr_q.size());
    end
    run_op(2'b01, 16'h0, 32'h0, 1'b0, 3'b0, "pop_word");
    cnt_cmp++;
    if (o_data !== 16'hABCD) begin
      cnt_fail++; $display("FAIL vec_pop_word: got %h want abcd", o_data);
    end
    run_op(2'b10, 16'h0, 32'h0001_2345, 1'b1, 3'b101, "push_pc");
    cnt_cmp++;
    if (wr_q.size() != 2 || wr_q[0] !== 32'h07FF_A001 || wr_q[1] !== 32'h07FE_2345 || o_sp !== 16'h07FD) begin
      cnt_fail++; $display("FAIL vec_push_pc: got %0d writes sp %h want 07ffa001,07fe2345 sp 07fd", wr_q.size(), o_sp);
    end
    run_op(2'b11, 16'h0, 32'h0, 1'b1, 3'b0, "pop_pc");
    cnt_cmp++;
    if (o_pc !== 32'h0001_2345 || o_flags !== 3'b101 || o_sp !== 16'h07FF) begin
      cnt_fail++; $display("FAIL vec_pop_pc: got pc %h flags %b sp %h want 00012345 101 07ff", o_pc, o_flags, o_sp);
    end
    if (GUARD) run_op(2'b01, 16'h0, 32'h0, 1'b0, 3'b0, "pop_underflow");
  endtask

  task automatic test_limit();
    while (m_sp != STACK_LIMIT) begin
      if (m_sp >= STACK_LIMIT + 16'd2) run_op(2'b10, 16'h0, $urandom, 1'($urandom), 3'($urandom), "fill_pc");
      else run_op(2'b00, 16'($urandom), 32'h0, 1'b0, 3'b0, "fill_word");
    end
    run_op(2'b10, 16'h0, 32'hDEAD_BEEF, 1'b0, 3'b0, "limit_push_pc");
    run_op(2'b00, 16'h5A5A, 32'h0, 1'b0, 3'b0, "limit_push_word");
  endtask

  task automatic test_random();
    logic [1:0] op;
    int         n;
    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom_range(0, 3));
      n  = op[1] ? 2 : 1;
      if (op[0] && (int'(m_sp) + n > int'(SP_INIT)) && !(GUARD && $urandom_range(0, 3) == 0))
        op[0] = 1'b0;
      run_op(op, 16'($urandom), $urandom, 1'($urandom), 3'($urandom), "rand");
    end
  endtask

  task automatic test_reset_mid_pop();
    @(negedge i_clk);
    i_valid = 1'b1; i_op = 2'b11; i_flags_en = 1'b0;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    @(posedge i_clk);
    #1 i_reset = 1'b0;
    wr_q.delete(); rd_q.delete(); done_seen = 0;
    m_sp = SP_INIT; m_data = '0; m_pc = '0; m_flags = '0;
    #1;
    cnt_cmp++;
    if (o_ready !== 1'b1 || o_sp !== SP_INIT || o_mem_re !== 1'b0 || o_mem_we !== 1'b0 || o_done !== 1'b0) begin
      cnt_fail++; $display("FAIL midpop_reset: got ready %b sp %h re %b we %b done %b want 1 07ff 0 0 0",
                           o_ready, o_sp, o_mem_re, o_mem_we, o_done);
    end
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;
    repeat (6) @(negedge i_clk);
    cnt_cmp++;
    if (rd_q.size() != 0 || wr_q.size() != 0 || done_seen != 0 || o_sp !== SP_INIT) begin
      cnt_fail++; $display("FAIL midpop_quiet: got rd %0d wr %0d done %0d sp %h want 0 0 0 07ff",
                           rd_q.size(), wr_q.size(), done_seen, o_sp);
    end
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_vectors();
    test_limit();
    test_reset_mid_pop();
    test_random();
    cnt_cmp++;
    if (both_cnt != 0) begin
      cnt_fail++; $display("FAIL we_re_overlap: got %0d cycles want 0", both_cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_fail);
    $finish;
  end

endmodule

// File: doc/exm_stack_unit.md
EXM_STACK_UNIT -- requirements
Module: exm_stack_unit

Interface
REQ-001 SHALL have parameters (name, default, meaning): DATA_W, 16, memory word width; ADDR_W, 16, stack address width; PC_W, 32, PC width, a multiple of DATA_W; SP_INIT, 'h07FF, SP reset value and top of stack; STACK_LIMIT, 'h0400, lowest legal stack address.
REQ-002 SHALL define NW = PC_W/DATA_W, the number of words per PC transfer.
REQ-003 SHALL use a single clock and an asynchronous, active-low reset, with ports (name, direction, width, meaning) as follows.
REQ-004 i_clk  in  1  clock, all state updates on the rising edge.
REQ-005 i_reset  in  1  asynchronous, active-low reset.
REQ-006 i_valid  in  1  request valid; i_op  in  2  operation: 00 push word, 01 pop word, 10 push PC, 11 pop PC.
REQ-007 i_data  in  DATA_W  push word; i_pc  in  PC_W  PC to push; i_flags_en  in  1  save/restore flags; i_flags  in  3  {Z,N,C}.
REQ-008 o_ready  out  1  unit idle, request accepted on i_valid & o_ready.
REQ-009 o_mem_addr  out  ADDR_W  memory address; o_mem_wdata  out  DATA_W  write data; o_mem_we, o_mem_re  out  1  strobes; i_mem_rdata  in  DATA_W  read data, valid one cycle after o_mem_re.
REQ-010 o_done  out  1  one-cycle completion pulse; o_error  out  1  bound violation, valid with o_done.
REQ-011 o_data  out  DATA_W  popped word; o_pc  out  PC_W  popped PC; o_flags  out  3  restored flags; o_flags_valid  out  1  o_flags meaningful, valid with o_done.
REQ-012 o_sp  out  ADDR_W  current stack pointer, a registered value.

Function
REQ-013 The FSM states SHALL be IDLE, PUSH, POP, DRAIN and DONE; o_ready SHALL be 1 only in IDLE.
REQ-014 An accept at cycle T SHALL latch i_op, i_data, i_pc, i_flags_en and i_flags; requests while not ready are ignored, and the requester holds them.
REQ-015 Push SHALL write at SP then decrement SP by 1, one word per cycle from T+1; push word uses n=1, push PC uses n=NW, most-significant word first.
REQ-016 Push PC with i_flags_en SHALL replace the top 3 bits of the most-significant word with {Z,N,C}.
REQ-017 Pop SHALL increment SP by 1 then read at the new SP, one read per cycle from T+1; pop PC reads the least-significant word first.
REQ-018 Pop SHALL capture read data in DRAIN and assemble o_pc; with i_flags_en, o_flags equals the top 3 bits of the most-significant word, those o_pc bits are zeroed, and o_flags_valid is 1.
REQ-019 Push SHALL pulse o_done at T+n+1; pop SHALL pulse o_done at T+n+2.
REQ-020 The unit SHALL return to IDLE the cycle after DONE.
REQ-021 Outputs o_data, o_pc and o_flags SHALL hold until the next pop completes.
REQ-022 o_mem_we and o_mem_re SHALL never both be 1, and both SHALL be 0 outside the PUSH and POP states.
REQ-023 SP arithmetic SHALL be modulo 2^ADDR_W.

Reset
REQ-024 On reset assertion, asynchronously: state is IDLE, SP is SP_INIT, and all outputs are 0 except o_ready=1 and o_sp=SP_INIT.
REQ-025 Reset mid-operation SHALL abort with no further memory strobes and no o_done.

Configuration
REQ-026 With EXM_STACK_GUARD_EN defined, push SHALL require SP-n+1 >= STACK_LIMIT and pop SHALL require SP+n <= SP_INIT.
REQ-027 On a guard violation, the unit SHALL go directly to DONE at T+1 with o_done=1 and o_error=1, issue no memory strobes, and leave SP unchanged.
REQ-028 Without EXM_STACK_GUARD_EN, the unit SHALL perform no checks, SP SHALL wrap, and o_error SHALL be tied to 0.

Verification (default parameters, guard enabled)
REQ-029 Reset, then push word 0xABCD at T -> T+1: we=1, addr 0x07FF, wdata 0xABCD; T+2: o_done=1, o_sp 0x07FE.
REQ-030 Push PC 0x00012345 with flags 101 and flags_en from SP 0x07FF -> writes (0x07FF, 0xA001) then (0x07FE, 0x2345); o_sp 0x07FD.
REQ-031 Then pop PC with flags_en -> reads 0x07FE then 0x07FF; o_done at T+4; o_pc 0x00012345, o_flags 101, o_flags_valid=1, o_sp 0x07FF.
REQ-032 Pop word at SP 0x07FF -> T+1: o_done=1, o_error=1, no o_mem_re, o_sp 0x07FF.
REQ-033 SP 0x0400, push PC -> o_error=1 with no write; push word -> write at 0x0400, o_error=0, o_sp 0x03FF.
REQ-034 Assert i_reset after the first read of a pop PC -> no further strobes, no o_done, o_sp 0x07FF, o_ready=1.
